decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage between instruction fetch and execute in the RV32I core.
- Registers each fetched instruction word and its PC, and classifies the opcode into the 3-bit instruction-type code used by the immediate encoder.
- Extracts register indices and funct fields, and flags illegal encodings.
- Uses a valid/ready handshake on both sides; supports flush for taken branches and jumps.

Parameters:
- XLEN, 32, width of the PC and data path.
- RESET_PC, 32'h0000_0000, value driven on out_pc while the stage is empty after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard the held instruction and any instruction accepted this cycle.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  stage can accept the instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded instruction held for execute.
- out_ready  in  1  execute consumes the held instruction this cycle.
- out_instr  out  32  registered instruction word; bits [31:7] feed the immediate encoder.
- out_pc  out  XLEN  registered PC.
- out_instr_type  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 111 R/none.
- out_rd, out_rs1, out_rs2  out  5 each  register fields, instr[11:7], [19:15], [24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_reg_write  out  1  instruction writes rd, and rd != 0.
- out_use_rs1, out_use_rs2  out  1 each  source operands are read.
- out_illegal  out  1  unsupported or malformed encoding.

Behaviour:
- **Storage:** one-entry pipeline register. in_ready = !out_valid || out_ready, combinational, never dependent on in_valid.
- **Accept:** in_valid && in_ready && !flush at the edge loads all out_* fields and sets out_valid = 1. Latency is one cycle from accept to out_valid.
- **Consume without refill:** out_valid && out_ready with no accept clears out_valid. Simultaneous consume and accept gives back-to-back throughput of one instruction per cycle.
- **Hold:** while out_valid && !out_ready, every out_* field is stable.
- **Flush:** out_valid <= 0 next edge. An instruction offered in the same cycle is dropped, even though in_ready may read 1. Flush has priority over accept and consume.
- **Reset:**
  - out_valid = 0, out_pc = RESET_PC, out_instr = 32'h0000_0013 (NOP).
  - out_instr_type = 000, rd/rs1/rs2/funct3/funct7 = 0.
  - out_reg_write = 0, out_use_rs1 = 0, out_use_rs2 = 0, out_illegal = 0.
  - Reset mid-stall discards the held instruction.
  - Reset dominates flush and accept.
- **Opcode classification:** instr[6:0] mapped as follows.
  - I-type: LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011.
  - S-type: STORE 0100011.
  - B-type: BRANCH 1100011.
  - U-type: LUI 0110111, AUIPC 0010111.
  - J-type: JAL 1101111.
  - R/none (111): OP 0110011.
  - Any other opcode, or instr[1:0] != 11: out_illegal = 1, out_instr_type = 111, out_reg_write = 0, out_use_rs1 = 0, out_use_rs2 = 0.
- **reg_write:** 1 for all types except S and B, MISC-MEM, and illegal; then ANDed with (rd != 0).
- **use_rs1:** 1 for all types except U, J, and illegal.
- **use_rs2:** 1 for S, B and OP only.
- **Empty stage:** out_* fields hold their last loaded values while out_valid = 0; consumers must qualify with out_valid.
- Decode fields are computed from in_instr before the register, so the outputs are register-only.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams (OPC_LOAD … OPC_SYSTEM);
  - typedef enum logic[2:0] instr_type_t {IT_I=0, IT_S=1, IT_B=2, IT_U=3, IT_J=4, IT_R=7};
  - NOP_INSTR = 32'h0000_0013.
- The immediate encoder switches to instr_type_t from the same package.
- One combinational sub-module, opcode_decode: takes instr[6:0], produces instr_type, reg_write_raw, use_rs1, use_rs2 and illegal. The register stage and handshake stay in decode_stage.

Test Plan:
- Accept addi x1,x0,5 (32'h0050_0093, pc 0x100), out_ready=1 → next cycle out_valid=1, type 000, rd=1, rs1=0, reg_write=1, use_rs1=1, use_rs2=0, illegal=0.
- sw x2,8(x1) (32'h0020_A423) → type 001, rs1=1, rs2=2, reg_write=0, use_rs2=1. lui x5,0x12345 (32'h1234_52B7) → type 011, rd=5, use_rs1=0.
- Backpressure: load an instruction, hold out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, outputs constant. Raise out_ready → next instruction loads on that same edge, no bubble.
- Flush: out_valid=1 with in_valid=1 and flush=1 in the same cycle → next cycle out_valid=0, in_instr not captured.
- Illegal: 32'h0000_0000 → illegal=1, type 111, reg_write=0. addi x0,x0,0 (NOP) → reg_write=0, illegal=0.
- rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_pc=RESET_PC, in_ready=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: major opcodes, instruction-type codes and the NOP word.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IT_I = 3'd0,
    IT_S = 3'd1,
    IT_B = 3'd2,
    IT_U = 3'd3,
    IT_J = 3'd4,
    IT_R = 3'd7
  } instr_type_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/opcode_decode.sv
// Combinational major-opcode classifier: instruction type, operand usage and illegal flag.
module opcode_decode
  import rv_pkg::*;
(
  input  logic [6:0]  opcode,
  output instr_type_t instr_type,
  output logic        reg_write_raw,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        illegal
);

  always_comb begin
    instr_type    = IT_R;
    reg_write_raw = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    illegal       = 1'b0;
    // Every legal opcode ends in 2'b11, so the default arm also catches compressed encodings.
    unique case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        instr_type    = IT_I;
        reg_write_raw = 1'b1;
        use_rs1       = 1'b1;
      end
      OPC_MISC_MEM: begin
        instr_type = IT_I;
        use_rs1    = 1'b1;
      end
      OPC_STORE: begin
        instr_type = IT_S;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_BRANCH: begin
        instr_type = IT_B;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        instr_type    = IT_U;
        reg_write_raw = 1'b1;
      end
      OPC_JAL: begin
        instr_type    = IT_J;
        reg_write_raw = 1'b1;
      end
      OPC_OP: begin
        instr_type    = IT_R;
        reg_write_raw = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Fetch-to-execute decode stage: one-entry pipeline register with valid/ready handshake and flush.
module decode_stage
  import rv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_instr_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_reg_write,
  output logic            out_use_rs1,
  output logic            out_use_rs2,
  output logic            out_illegal
);

  instr_type_t dec_type;
  logic        dec_reg_write_raw;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic        dec_illegal;
  logic        accept;

  opcode_decode u_opcode_decode (
    .opcode        (in_instr[6:0]),
    .instr_type    (dec_type),
    .reg_write_raw (dec_reg_write_raw),
    .use_rs1       (dec_use_rs1),
    .use_rs2       (dec_use_rs2),
    .illegal       (dec_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_instr      <= NOP_INSTR;
      out_pc         <= RESET_PC;
      out_instr_type <= IT_I;
      out_rd         <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_funct3     <= '0;
      out_funct7     <= '0;
      out_reg_write  <= 1'b0;
      out_use_rs1    <= 1'b0;
      out_use_rs2    <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_instr      <= in_instr;
      out_pc         <= in_pc;
      out_instr_type <= dec_type;
      out_rd         <= in_instr[11:7];
      out_rs1        <= in_instr[19:15];
      out_rs2        <= in_instr[24:20];
      out_funct3     <= in_instr[14:12];
      out_funct7     <= in_instr[31:25];
      out_reg_write  <= dec_reg_write_raw && (in_instr[11:7] != 5'd0);
      out_use_rs1    <= dec_use_rs1;
      out_use_rs2    <= dec_use_rs2;
      out_illegal    <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed table, hand-written handshake sequences, random traffic.
module tb_decode_stage;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0400;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr, out_instr;
  logic [XLEN-1:0] in_pc, out_pc;
  logic [2:0]      out_instr_type, out_funct3;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [6:0]      out_funct7;
  logic            out_reg_write, out_use_rs1, out_use_rs2, out_illegal;

  decode_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_instr_type(out_instr_type), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_reg_write(out_reg_write),
    .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: what execute should currently see.
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_from_reset;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  typ;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, u1, u2, ill;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // Classify by the ISA's opcode map, then derive each flag from the class rules.
  function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] typ,
                                     output logic rw, output logic u1, output logic u2,
                                     output logic ill);
    byte cls;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: cls = "I";
      7'b0001111: cls = "M";
      7'b0100011: cls = "S";
      7'b1100011: cls = "B";
      7'b0110111, 7'b0010111: cls = "U";
      7'b1101111: cls = "J";
      7'b0110011: cls = "R";
      default:    cls = "X";
    endcase
    ill = (cls == "X");
    case (cls)
      "I", "M": typ = 3'd0;
      "S":      typ = 3'd1;
      "B":      typ = 3'd2;
      "U":      typ = 3'd3;
      "J":      typ = 3'd4;
      default:  typ = 3'd7;
    endcase
    rw = !(cls inside {"S", "B", "M", "X"}) && (ins[11:7] != 0);
    u1 = !(cls inside {"U", "J", "X"});
    u2 = cls inside {"S", "B", "R"};
  endfunction

  task automatic cmp_all();
    logic [2:0] t;
    logic rw, u1, u2, ill;
    ref_decode(m_instr, t, rw, u1, u2, ill);
    if (m_from_reset) begin
      t = 0; rw = 0; u1 = 0; u2 = 0; ill = 0;
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_instr", out_instr, m_instr);
    chk("out_pc", out_pc, m_pc);
    chk("out_instr_type", out_instr_type, t);
    chk("out_rd", out_rd, m_from_reset ? 5'd0 : m_instr[11:7]);
    chk("out_rs1", out_rs1, m_from_reset ? 5'd0 : m_instr[19:15]);
    chk("out_rs2", out_rs2, m_from_reset ? 5'd0 : m_instr[24:20]);
    chk("out_funct3", out_funct3, m_from_reset ? 3'd0 : m_instr[14:12]);
    chk("out_funct7", out_funct7, m_from_reset ? 7'd0 : m_instr[31:25]);
    chk("out_reg_write", out_reg_write, rw);
    chk("out_use_rs1", out_use_rs1, u1);
    chk("out_use_rs2", out_use_rs2, u2);
    chk("out_illegal", out_illegal, ill);
  endtask

  task automatic step();
    bit acc;
    #1;
    chk("in_ready", in_ready, !m_valid || out_ready);
    acc = in_valid && (!m_valid || out_ready) && !flush;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_instr = NOP; m_pc = RESET_PC; m_from_reset = 1;
    end else if (flush) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m_instr = in_instr; m_pc = in_pc; m_from_reset = 0;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    cmp_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  logic [6:0] legal_opc[11] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0100011,
                                7'b0110011, 7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111,
                                7'b1110011};

  initial begin
    logic [31:0] r, held;
    tab[0] = '{32'h0050_0093, 32'h100, 3'd0, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0}; // addi x1,x0,5
    tab[1] = '{32'h0020_A423, 32'h104, 3'd1, 5'd8, 5'd1, 5'd2, 0, 1, 1, 0}; // sw x2,8(x1)
    tab[2] = '{32'h1234_52B7, 32'h108, 3'd3, 5'd5, 5'd8, 5'd3, 1, 0, 0, 0}; // lui x5,0x12345
    tab[3] = '{32'h0000_0000, 32'h10C, 3'd7, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1}; // all-zero word
    tab[4] = '{32'h0000_0013, 32'h110, 3'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0}; // nop
    tab[5] = '{32'h0020_81B3, 32'h114, 3'd7, 5'd3, 5'd1, 5'd2, 1, 1, 1, 0}; // add x3,x1,x2
    tab[6] = '{32'h0020_8463, 32'h118, 3'd2, 5'd8, 5'd1, 5'd2, 0, 1, 1, 0}; // beq x1,x2,8
    tab[7] = '{32'h0000_000F, 32'h11C, 3'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0}; // fence

    rst = 1; drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    m_valid = 0; m_instr = NOP; m_pc = RESET_PC; m_from_reset = 1;
    #1;
    cmp_all();
    chk("reset in_ready", in_ready, 1);
    rst = 0;

    // Directed decode table, streamed back-to-back.
    foreach (tab[i]) begin
      drive(1, tab[i].instr, tab[i].pc, 1, 0);
      step();
      chk("tab out_valid", out_valid, 1);
      chk("tab type", out_instr_type, tab[i].typ);
      chk("tab rd", out_rd, tab[i].rd);
      chk("tab rs1", out_rs1, tab[i].rs1);
      chk("tab rs2", out_rs2, tab[i].rs2);
      chk("tab reg_write", out_reg_write, tab[i].rw);
      chk("tab use_rs1", out_use_rs1, tab[i].u1);
      chk("tab use_rs2", out_use_rs2, tab[i].u2);
      chk("tab illegal", out_illegal, tab[i].ill);
      chk("tab pc", out_pc, tab[i].pc);
    end
    drive(0, 0, 0, 1, 0); step();
    chk("drain valid", out_valid, 0);

    // Backpressure: hold for 3 cycles, then release with refill on the same edge.
    drive(1, tab[0].instr, 32'h200, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive(1, tab[5].instr, 32'h204, 0, 0);
      #1 chk("stall in_ready", in_ready, 0);
      step();
      chk("stall instr", out_instr, tab[0].instr);
      chk("stall pc", out_pc, 32'h200);
    end
    drive(1, tab[5].instr, 32'h204, 1, 0);
    #1 chk("release in_ready", in_ready, 1);
    step();
    chk("release valid", out_valid, 1);
    chk("release instr", out_instr, tab[5].instr);

    // Flush while full with a new offer: offer dropped, stage empties.
    held = out_instr;
    drive(1, tab[2].instr, 32'h300, 0, 1); step();
    chk("flush valid", out_valid, 0);
    chk("flush no capture", out_instr, held);
    drive(0, 0, 0, 0, 0); step();
    chk("flush stays empty", out_valid, 0);

    // Reset in the middle of a stall.
    drive(1, tab[1].instr, 32'h500, 0, 0); step();
    rst = 1; drive(1, tab[6].instr, 32'h504, 0, 0); step();
    chk("rst valid", out_valid, 0);
    chk("rst pc", out_pc, RESET_PC);
    chk("rst in_ready", in_ready, 1);
    chk("rst instr", out_instr, NOP);
    rst = 0;

    // Random traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      r = $urandom();
      if ($urandom_range(1, 0) == 1) r = {r[31:7], legal_opc[$urandom_range(10, 0)]};
      rst = ($urandom_range(199, 0) == 0);
      drive($urandom_range(9, 0) < 7, r, $urandom(), $urandom_range(9, 0) < 6,
            $urandom_range(9, 0) == 0);
      step();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
